fpaa_prog_addr_tx: RTL and testbench

//  Programming-side transmitter for the CAB fabric's programming mux. Accepts one address

---
 rtl/fpaa_prog_addr_tx_if.sv | 28 ++
 rtl/fpaa_prog_addr_tx.sv | 159 +++++++++++++++
 tb/tb_fpaa_prog_addr_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpaa_prog_addr_tx_if.sv
// Command handshake between the programming sequencer (master) and the address transmitter (slave).
interface fpaa_prog_addr_tx_if #(
    parameter int ISL_W   = 4,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3,
    parameter int MROW_W  = 4,
    parameter int MCOL_W  = 4,
    parameter int PULSE_W = 16
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ISL_W-1:0]   cmd_island;
    logic [ROW_W-1:0]   cmd_row;
    logic [COL_W-1:0]   cmd_col;
    logic [MROW_W-1:0]  cmd_mrow;
    logic [MCOL_W-1:0]  cmd_mcol;
    logic [PULSE_W-1:0] cmd_pulse;

    modport master (
        output cmd_valid, cmd_island, cmd_row, cmd_col, cmd_mrow, cmd_mcol, cmd_pulse,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_island, cmd_row, cmd_col, cmd_mrow, cmd_mcol, cmd_pulse,
        output cmd_ready
    );
endinterface

// File: rtl/fpaa_prog_addr_tx.sv
// Programming-side transmitter: accepts one address command, shifts it MSB first onto the
// fabric select chain, strobes the decoder latch, then drives a programming pulse.
module fpaa_prog_addr_tx #(
    parameter int ISL_W    = 4,
    parameter int ROW_W    = 3,
    parameter int COL_W    = 3,
    parameter int MROW_W   = 4,
    parameter int MCOL_W   = 4,
    parameter int NUM_ROWS = 1,
    parameter int NUM_COLS = 7,
    parameter int CLK_DIV  = 2,
    parameter int PULSE_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    fpaa_prog_addr_tx_if.slave  cmd,
    output logic                sclk,
    output logic                sdata,
    output logic                slatch,
    output logic                prog_en,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int N     = ISL_W + ROW_W + COL_W + MROW_W + MCOL_W;
    localparam int BIT_W = $clog2(N + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [31:0] ROW_LIM = 32'(NUM_ROWS);
    localparam logic [31:0] COL_LIM = 32'(NUM_COLS);

    typedef enum logic [2:0] {
        IDLE, CHECK, SHIFT, LATCH, PULSE, DONE, REJ
    } state_t;

    state_t             state;
    logic               ready;
    logic [N-1:0]       frame;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [PULSE_W-1:0] pulse_len;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [BIT_W-1:0]   bits_left;
    logic [DIV_W-1:0]   div_cnt;
    logic               out_of_range;

    assign cmd.cmd_ready = ready;
    assign out_of_range  = (32'(row) >= ROW_LIM) || (32'(col) >= COL_LIM);

    // frame is consumed from its MSB; sdata is reloaded only after a full high half of sclk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b0;
            frame     <= '0;
            row       <= '0;
            col       <= '0;
            pulse_len <= '0;
            pulse_cnt <= '0;
            bits_left <= '0;
            div_cnt   <= '0;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            slatch    <= 1'b0;
            prog_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid && ready) begin
                        frame     <= {cmd.cmd_island, cmd.cmd_row, cmd.cmd_col,
                                      cmd.cmd_mrow, cmd.cmd_mcol};
                        row       <= cmd.cmd_row;
                        col       <= cmd.cmd_col;
                        pulse_len <= cmd.cmd_pulse;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                CHECK: begin
                    if (out_of_range) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= REJ;
                    end else begin
                        sdata     <= frame[N-1];
                        frame     <= {frame[N-2:0], 1'b0};
                        sclk      <= 1'b0;
                        div_cnt   <= '0;
                        bits_left <= BIT_W'(N - 1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bits_left != '0) begin
                            sclk      <= 1'b0;
                            sdata     <= frame[N-1];
                            frame     <= {frame[N-2:0], 1'b0};
                            bits_left <= bits_left - 1'b1;
                        end else begin
                            sclk   <= 1'b0;
                            sdata  <= 1'b0;
                            slatch <= 1'b1;
                            state  <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        slatch  <= 1'b0;
                        if (pulse_len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            prog_en   <= 1'b1;
                            pulse_cnt <= pulse_len;
                            state     <= PULSE;
                        end
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PULSE_W'(1)) begin
                        prog_en <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                REJ: begin
                    err   <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpaa_prog_addr_tx.sv
// Bench for fpaa_prog_addr_tx: two instances (CLK_DIV=2 and CLK_DIV=1) checked against a
// command-level model of frame contents, pulse lengths and accept->done latency.
module tb_fpaa_prog_addr_tx;
    localparam int N        = 18;
    localparam int NUM_ROWS = 1;
    localparam int NUM_COLS = 7;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  isl   = '0;
    logic [2:0]  row   = '0;
    logic [2:0]  col   = '0;
    logic [3:0]  mrow  = '0;
    logic [3:0]  mcol  = '0;
    logic [15:0] pulse = '0;
    int total = 0;
    int bad   = 0;

    logic sclk_a, sdata_a, slatch_a, prog_a, busy_a, done_a, err_a;
    logic sclk_b, sdata_b, slatch_b, prog_b, busy_b, done_b, err_b;
    logic obs_sclk, obs_sdata, obs_slatch, obs_prog, obs_busy, obs_done, obs_err, obs_ready;

    fpaa_prog_addr_tx_if if_a ();
    fpaa_prog_addr_tx_if if_b ();

    assign if_a.cmd_valid  = valid & ~sel;
    assign if_a.cmd_island = isl;
    assign if_a.cmd_row    = row;
    assign if_a.cmd_col    = col;
    assign if_a.cmd_mrow   = mrow;
    assign if_a.cmd_mcol   = mcol;
    assign if_a.cmd_pulse  = pulse;
    assign if_b.cmd_valid  = valid & sel;
    assign if_b.cmd_island = isl;
    assign if_b.cmd_row    = row;
    assign if_b.cmd_col    = col;
    assign if_b.cmd_mrow   = mrow;
    assign if_b.cmd_mcol   = mcol;
    assign if_b.cmd_pulse  = pulse;

    fpaa_prog_addr_tx #(.CLK_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .cmd(if_a),
        .sclk(sclk_a), .sdata(sdata_a), .slatch(slatch_a), .prog_en(prog_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    fpaa_prog_addr_tx #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .cmd(if_b),
        .sclk(sclk_b), .sdata(sdata_b), .slatch(slatch_b), .prog_en(prog_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    assign obs_sclk   = sel ? sclk_b   : sclk_a;
    assign obs_sdata  = sel ? sdata_b  : sdata_a;
    assign obs_slatch = sel ? slatch_b : slatch_a;
    assign obs_prog   = sel ? prog_b   : prog_a;
    assign obs_busy   = sel ? busy_b   : busy_a;
    assign obs_done   = sel ? done_b   : done_a;
    assign obs_err    = sel ? err_b    : err_a;
    assign obs_ready  = sel ? if_b.cmd_ready : if_a.cmd_ready;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one command on the selected instance and judges everything seen until it completes.
    task automatic applyStimulus(input logic [3:0] i_isl, input logic [2:0] i_row,
                                 input logic [2:0] i_col, input logic [3:0] i_mrow,
                                 input logic [3:0] i_mcol, input logic [15:0] i_pulse,
                                 input bit hold);
        int div, lat, limit, n, j, tail;
        int rises, last_rise, bad_period, sclk_hi, latch_cyc, pe_cyc, overlap, stable_bad;
        int err_cyc, err_at, done_cyc, done_at, busy_bad, ready_bad, frame_got, frame_exp;
        bit reject;
        logic prev_sclk, prev_sdata;

        div       = sel ? 1 : 2;
        reject    = (int'(i_row) >= NUM_ROWS) || (int'(i_col) >= NUM_COLS);
        lat       = 1 + 2 * N * div + div + int'(i_pulse) + 1;
        limit     = reject ? 12 : lat + 20;
        frame_exp = int'(i_isl) * 16384 + int'(i_row) * 2048 + int'(i_col) * 256
                  + int'(i_mrow) * 16 + int'(i_mcol);

        isl = i_isl; row = i_row; col = i_col; mrow = i_mrow; mcol = i_mcol; pulse = i_pulse;
        valid = 1'b1;
        n = 0;
        while (obs_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_wait", int'(obs_ready === 1'b1), 1);
        if (obs_ready !== 1'b1) begin
            valid = 1'b0;
            return;
        end

        rises = 0; last_rise = 0; bad_period = 0; sclk_hi = 0; latch_cyc = 0; pe_cyc = 0;
        overlap = 0; stable_bad = 0; err_cyc = 0; err_at = -1; done_cyc = 0; done_at = -1;
        busy_bad = 0; ready_bad = 0; frame_got = 0;
        prev_sclk = obs_sclk; prev_sdata = obs_sdata;
        tail = -1; j = 0;
        while (j < limit && tail != 0) begin
            @(negedge clk);
            j++;
            if (j == 1 && !hold) valid = 1'b0;
            if (obs_sclk && !prev_sclk) begin
                rises++;
                frame_got = (frame_got << 1) | int'(obs_sdata);
                if (rises > 1 && j - last_rise != 2 * div) bad_period++;
                last_rise = j;
            end
            if (obs_sclk) sclk_hi++;
            if (obs_sclk && prev_sclk && obs_sdata !== prev_sdata) stable_bad++;
            prev_sclk = obs_sclk;
            prev_sdata = obs_sdata;
            if (obs_slatch) latch_cyc++;
            if (obs_prog) pe_cyc++;
            if ((obs_slatch && obs_prog) || (obs_sclk && (obs_slatch || obs_prog))) overlap++;
            if ((obs_slatch || obs_prog || obs_done) && obs_sdata) overlap++;
            if (obs_err) begin err_cyc++; err_at = j; end
            if (obs_done) begin done_cyc++; done_at = j; end
            if (obs_busy !== (reject ? (j == 1) : (j <= lat))) busy_bad++;
            if (obs_ready !== (reject ? (j >= 3) : (j > lat))) ready_bad++;
            if (tail > 0) tail--;
            else if (tail < 0 && (obs_done || obs_err)) tail = hold ? 1 : 4;
        end

        checkOutput("sclk_rises", rises, reject ? 0 : N);
        checkOutput("sclk_high_cycles", sclk_hi, reject ? 0 : N * div);
        checkOutput("frame", frame_got, reject ? 0 : frame_exp);
        checkOutput("sclk_period", bad_period, 0);
        checkOutput("sdata_stable", stable_bad, 0);
        checkOutput("slatch_cycles", latch_cyc, reject ? 0 : div);
        checkOutput("prog_en_cycles", pe_cyc, reject ? 0 : int'(i_pulse));
        checkOutput("done_count", done_cyc, reject ? 0 : 1);
        checkOutput("done_latency", done_at, reject ? -1 : lat);
        checkOutput("err_count", err_cyc, reject ? 1 : 0);
        checkOutput("err_latency", err_at, reject ? 2 : -1);
        checkOutput("exclusive_outputs", overlap, 0);
        checkOutput("busy_profile", busy_bad, 0);
        checkOutput("ready_profile", ready_bad, 0);
    endtask

    initial begin
        int n, rises, activity;
        logic prev;

        // reset state on both instances
        repeat (3) @(negedge clk);
        checkOutput("ready_in_reset", int'(obs_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", int'(obs_ready), 1);
        checkOutput("outs_after_reset_a",
                    int'({sclk_a, sdata_a, slatch_a, prog_a, busy_a, done_a, err_a}), 0);
        checkOutput("outs_after_reset_b",
                    int'({sclk_b, sdata_b, slatch_b, prog_b, busy_b, done_b, err_b}), 0);

        // directed commands: nominal, out-of-range col/row, zero pulse
        applyStimulus(4'd0, 3'd0, 3'd6, 4'd7, 4'd1, 16'd5, 1'b0);
        applyStimulus(4'd3, 3'd0, 3'd7, 4'd2, 4'd2, 16'd5, 1'b0);
        applyStimulus(4'd9, 3'd1, 3'd0, 4'd1, 4'd8, 16'd3, 1'b0);
        applyStimulus(4'hF, 3'd0, 3'd0, 4'hF, 4'hF, 16'd0, 1'b0);

        // cmd_valid held high across three back-to-back commands
        applyStimulus(4'd5, 3'd0, 3'd2, 4'd3, 4'd4, 16'd2, 1'b1);
        applyStimulus(4'd6, 3'd0, 3'd5, 4'd9, 4'd0, 16'd0, 1'b1);
        applyStimulus(4'd7, 3'd0, 3'd1, 4'd6, 4'hC, 16'd4, 1'b0);

        for (int r = 0; r < 10; r++) begin
            logic [2:0] rr;
            rr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            applyStimulus(4'($urandom), rr, 3'($urandom_range(0, 7)), 4'($urandom),
                          4'($urandom), 16'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset asserted while shifting the ninth bit
        isl = 4'hA; row = 3'd0; col = 3'd3; mrow = 4'd5; mcol = 4'd9; pulse = 16'd4;
        valid = 1'b1;
        n = 0;
        while (obs_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        valid = 1'b0;
        rises = 0; n = 0; prev = obs_sclk;
        while (rises < 9 && n < 200) begin
            @(negedge clk);
            n++;
            if (obs_sclk && !prev) rises++;
            prev = obs_sclk;
        end
        checkOutput("rst_reach_bit", rises, 9);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_async_outs",
                    int'({obs_sclk, obs_sdata, obs_slatch, obs_prog, obs_busy, obs_done, obs_err}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready_after", int'(obs_ready), 1);
        activity = 0;
        repeat (100) begin
            @(negedge clk);
            if (obs_sclk || obs_sdata || obs_slatch || obs_prog || obs_busy || obs_done || obs_err)
                activity++;
        end
        checkOutput("rst_no_resume", activity, 0);

        // CLK_DIV=1 instance, finishing with the longest pulse
        sel = 1'b1;
        @(negedge clk);
        applyStimulus(4'($urandom), 3'd0, 3'($urandom_range(0, 6)), 4'($urandom),
                      4'($urandom), 16'($urandom_range(1, 6)), 1'b0);
        applyStimulus(4'd2, 3'd0, 3'd7, 4'd1, 4'd1, 16'd1, 1'b0);
        applyStimulus(4'd1, 3'd0, 3'd4, 4'hA, 4'h5, 16'hFFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
